// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOAD,
    ST_CHECK_FAIL,
    ST_DONE
  } ccff_state_e;

  localparam logic [31:0] DEFAULT_PREAMBLE = 32'h0000_00A5;

  // Counter width able to hold every shift index plus the terminal count.
  function automatic int ccff_cnt_w(input int chain_len, input int pre_w);
    return $clog2(chain_len + pre_w + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one host word and hands it out bit by bit, LSB first, with a registered
// ready that rises in the cycle the final bit of the current word is shifting.
module ccff_word_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              arm,
  input  logic              take,
  input  logic              take_last,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              bit_avail,
  output logic              bit_val
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W:0] FULL_C = (IDX_W + 1)'(DATA_W);
  localparam logic [IDX_W:0] ONE_C  = (IDX_W + 1)'(1);

  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              empty_q;
  logic              accept;
  logic [IDX_W:0]    next_idx;
  logic              word_full;

  always_comb begin
    accept    = bs_valid & bs_ready;
    bit_avail = !empty_q || accept;
    bit_val   = empty_q ? bs_data[0] : word_q[idx_q];
    next_idx  = empty_q ? ONE_C : ({1'b0, idx_q} + ONE_C);
    word_full = (next_idx == FULL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bs_ready <= 1'b0;
      empty_q  <= 1'b1;
      idx_q    <= '0;
    end else if (take) begin
      // The final data bit empties the register and ends the host handshake.
      if (take_last || word_full) begin
        empty_q  <= 1'b1;
        bs_ready <= !take_last;
        idx_q    <= '0;
      end else begin
        empty_q  <= 1'b0;
        bs_ready <= 1'b0;
        idx_q    <= next_idx[IDX_W-1:0];
      end
    end else if (clear || arm) begin
      empty_q  <= 1'b1;
      idx_q    <= '0;
      bs_ready <= arm;
    end
  end

  always_ff @(posedge clk) begin
    if (take && empty_q) word_q <= bs_data;
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Shifts a preamble followed by the host bitstream into a configuration chain and
// confirms the preamble reaches ccff_tail exactly as the last configuration bit enters.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int          CHAIN_LEN = 20,
  parameter int          DATA_W    = 8,
  parameter int          PRE_W     = 8,
  parameter logic [31:0] PREAMBLE  = DEFAULT_PREAMBLE,
  parameter int          CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  shift_cnt
);

  localparam int DCNT_W = ccff_cnt_w(CHAIN_LEN, 0);
  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CHAIN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_C     = CNT_W'(CHAIN_LEN + PRE_W - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST_C = CNT_W'(PRE_W - 1);
  localparam logic [4:0]        PRE_ARM_C  = 5'(PRE_W - 1);
  localparam logic [DCNT_W-1:0] DCHAIN_C   = DCNT_W'(CHAIN_LEN);
  localparam logic [DCNT_W-1:0] DLAST_C    = DCNT_W'(CHAIN_LEN - 1);
  localparam logic [DCNT_W-1:0] DONE_C     = DCNT_W'(1);

  ccff_state_e       state_q, state_d;
  logic              head_d, en_d, busy_d, done_d, error_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DCNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [4:0]        tail_idx, pre_idx_next;
  logic              mismatch, want_data;
  logic              ser_clear, ser_arm, take, take_last, bit_avail, bit_val;

  ccff_word_serializer #(.DATA_W(DATA_W)) u_serializer (
    .clk       (prog_clk),
    .rst       (pReset),
    .clear     (ser_clear),
    .arm       (ser_arm),
    .take      (take),
    .take_last (take_last),
    .bs_data   (bs_data),
    .bs_valid  (bs_valid),
    .bs_ready  (bs_ready),
    .bit_avail (bit_avail),
    .bit_val   (bit_val)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    head_d       = ccff_head;
    en_d         = 1'b0;
    busy_d       = busy;
    done_d       = done;
    error_d      = error;
    cnt_d        = prog_clk_en ? shift_cnt + ONE_C : shift_cnt;
    data_cnt_d   = data_cnt_q;
    ser_clear    = 1'b0;
    ser_arm      = 1'b0;
    take         = 1'b0;
    take_last    = 1'b0;
    want_data    = 1'b0;
    tail_idx     = 5'(shift_cnt - CHAIN_C);
    pre_idx_next = 5'(shift_cnt + ONE_C);
    // The tail is only meaningful once the first preamble bit has crossed the chain.
    mismatch     = prog_clk_en && (shift_cnt >= CHAIN_C) && (ccff_tail != PREAMBLE[tail_idx]);

    case (state_q)
      ST_IDLE, ST_DONE, ST_CHECK_FAIL: begin
        if (start) begin
          state_d    = ST_PRE;
          head_d     = PREAMBLE[0];
          en_d       = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cnt_d      = '0;
          data_cnt_d = '0;
          ser_clear  = 1'b1;
          ser_arm    = (PRE_W == 1);
        end
      end
      ST_PRE: begin
        if (mismatch) begin
          state_d   = ST_CHECK_FAIL;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          ser_clear = 1'b1;
        end else if (shift_cnt == PRE_LAST_C) begin
          state_d   = ST_LOAD;
          want_data = 1'b1;
        end else begin
          head_d  = PREAMBLE[pre_idx_next];
          en_d    = 1'b1;
          // Open the host port during the last preamble shift so data follows without a bubble.
          ser_arm = (pre_idx_next == PRE_ARM_C);
        end
      end
      ST_LOAD: begin
        if (mismatch) begin
          state_d   = ST_CHECK_FAIL;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          ser_clear = 1'b1;
        end else if (prog_clk_en && shift_cnt == LAST_C) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          want_data = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Without a bit to present the chain stalls and the head holds its value.
    if (want_data && (data_cnt_q < DCHAIN_C) && bit_avail) begin
      take       = 1'b1;
      take_last  = (data_cnt_q == DLAST_C);
      head_d     = bit_val;
      en_d       = 1'b1;
      data_cnt_d = data_cnt_q + DONE_C;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      shift_cnt   <= '0;
      data_cnt_q  <= '0;
    end else begin
      ccff_head   <= head_d;
      prog_clk_en <= en_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      shift_cnt   <= cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: a 20-flop chain model driven by prog_clk_en, host words 3C,81,0F,55.
module tb_ccff_bitstream_loader;

  localparam int CHAIN_LEN = 20;
  localparam int DATA_W    = 8;
  localparam int PRE_W     = 8;
  localparam int CNT_W     = 16;
  localparam logic [19:0] EXP_CHAIN = 20'hF813C;

  logic              prog_clk = 1'b0;
  logic              pReset, start, bs_valid;
  logic [DATA_W-1:0] bs_data;
  logic              bs_ready, ccff_head, prog_clk_en, ccff_tail, busy, done, error;
  logic [CNT_W-1:0]  shift_cnt;

  logic [19:0] chain = '0;
  logic        broken = 1'b0;
  logic        stuck = 1'b0;

  int checks = 0;
  int failures = 0;

  int   n_shift, first_sh, last_sh, taken, end_cyc;
  logic saw_done, saw_err;
  logic [7:0] words [4] = '{8'h3C, 8'h81, 8'h0F, 8'h55};

  always #5 prog_clk = ~prog_clk;

  // Chain model: bit 0 is the flop driving ccff_tail; a broken chain bypasses one flop.
  always @(posedge prog_clk) if (prog_clk_en) chain <= {ccff_head, chain[19:1]};
  assign ccff_tail = stuck ? 1'b0 : (broken ? chain[1] : chain[0]);

  ccff_bitstream_loader #(
    .CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W), .PRE_W(PRE_W),
    .PREAMBLE(32'h0000_00A5), .CNT_W(CNT_W)
  ) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .bs_data    (bs_data),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .ccff_head  (ccff_head),
    .prog_clk_en(prog_clk_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .shift_cnt  (shift_cnt)
  );

  task automatic step;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({bs_ready, ccff_head, prog_clk_en, busy, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL %s_outputs: ready/head/en/busy/done/error got %b%b%b%b%b%b want 000000",
               tag, bs_ready, ccff_head, prog_clk_en, busy, done, error);
    end
    checks++;
    if (shift_cnt !== '0) begin
      failures++;
      $display("FAIL %s_shift_cnt: got %0d want 0", tag, shift_cnt);
    end
  endtask

  // One load: start pulse, then host driver/monitor until done or error.
  task automatic run_load(input int stall_len, input int rst_at, input int start2_at,
                          output logic was_reset);
    int wi, stall_ctr;
    logic hs, en;
    logic [CNT_W-1:0] cnt_before;
    wi = 0; stall_ctr = 0; n_shift = 0; first_sh = -1; last_sh = -1;
    taken = 0; end_cyc = -1; saw_done = 0; saw_err = 0; was_reset = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if ({busy, prog_clk_en, done, error, ccff_head} !== 5'b11001 || shift_cnt !== '0) begin
      failures++;
      $display("FAIL start_state: busy/en/done/error/head got %b%b%b%b%b cnt %0d want 11001 cnt 0",
               busy, prog_clk_en, done, error, ccff_head, shift_cnt);
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done || error) begin
        saw_done = done; saw_err = error; end_cyc = cyc;
        break;
      end
      if (wi < 4 && taken == 1 && bs_ready && stall_ctr < stall_len) begin
        bs_valid = 1'b0;
        stall_ctr++;
      end else if (wi < 4) begin
        bs_valid = 1'b1;
        bs_data  = words[wi];
      end else begin
        bs_valid = 1'b0;
      end
      start = (cyc == start2_at);
      if (rst_at >= 0 && int'(shift_cnt) == rst_at) pReset = 1'b1;
      hs = bs_valid & bs_ready;
      en = prog_clk_en;
      cnt_before = shift_cnt;
      step;
      if (hs) begin wi++; taken++; end
      if (en) begin
        n_shift++;
        if (first_sh < 0) first_sh = cyc;
        last_sh = cyc;
      end
      if (cyc == start2_at) begin
        start = 1'b0;
        checks++;
        if (shift_cnt !== cnt_before + 16'd1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL start_busy_ignored: cnt %0d busy %b want cnt %0d busy 1",
                   shift_cnt, busy, cnt_before + 16'd1);
        end
      end
      if (pReset) begin
        pReset = 1'b0;
        bs_valid = 1'b0;
        was_reset = 1'b1;
        check_reset_values("mid_reset");
        return;
      end
    end
    bs_valid = 1'b0;
    start = 1'b0;
    if (end_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL load_timeout: no done/error within 200 cycles, got cnt %0d want completion", shift_cnt);
    end
  endtask

  task automatic check_good_load(input string tag, input int exp_end, input int exp_span);
    checks++;
    if (saw_done !== 1'b1 || saw_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_flags: done %b error %b want done 1 error 0", tag, saw_done, saw_err);
    end
    checks++;
    if (end_cyc != exp_end) begin
      failures++;
      $display("FAIL %s_latency: done at cycle %0d want %0d", tag, end_cyc, exp_end);
    end
    checks++;
    if (n_shift != 28 || (last_sh - first_sh + 1) != exp_span) begin
      failures++;
      $display("FAIL %s_shifts: count %0d span %0d want 28 span %0d",
               tag, n_shift, last_sh - first_sh + 1, exp_span);
    end
    checks++;
    if (shift_cnt !== 16'd28) begin
      failures++;
      $display("FAIL %s_shift_cnt: got %0d want 28", tag, shift_cnt);
    end
    checks++;
    if (chain !== EXP_CHAIN) begin
      failures++;
      $display("FAIL %s_chain: got %h want %h", tag, chain, EXP_CHAIN);
    end
    checks++;
    if (taken != 3 || busy !== 1'b0 || bs_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_host: words %0d busy %b ready %b want 3 0 0", tag, taken, busy, bs_ready);
    end
  endtask

  task automatic test_reset;
    pReset = 1'b1; start = 1'b1; bs_valid = 1'b0; bs_data = '0;
    repeat (3) step;
    check_reset_values("reset");
    pReset = 1'b0; start = 1'b0;
    step;
    checks++;
    if (busy !== 1'b0 || prog_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored: busy %b en %b want 0 0", busy, prog_clk_en);
    end
  endtask

  task automatic test_nominal;
    logic r;
    run_load(0, -1, -1, r);
    check_good_load("nominal", 28, 28);
    repeat (3) step;
    checks++;
    if (done !== 1'b1 || prog_clk_en !== 1'b0 || chain !== EXP_CHAIN) begin
      failures++;
      $display("FAIL nominal_hold: done %b en %b chain %h want 1 0 %h", done, prog_clk_en, chain, EXP_CHAIN);
    end
  endtask

  task automatic test_starvation;
    logic r;
    run_load(5, -1, -1, r);
    check_good_load("starve", 33, 33);
  endtask

  task automatic test_tail_fault(input string tag);
    logic r;
    run_load(0, -1, -1, r);
    checks++;
    if (saw_err !== 1'b1 || saw_done !== 1'b0 || end_cyc != 21) begin
      failures++;
      $display("FAIL %s_detect: error %b done %b at cycle %0d want 1 0 21", tag, saw_err, saw_done, end_cyc);
    end
    checks++;
    if (shift_cnt !== 16'd21 || taken != 2) begin
      failures++;
      $display("FAIL %s_stop: cnt %0d words %0d want 21 2", tag, shift_cnt, taken);
    end
    for (int i = 0; i < 4; i++) begin
      step;
      checks++;
      if (prog_clk_en !== 1'b0 || busy !== 1'b0 || error !== 1'b1 || bs_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold: en %b busy %b error %b ready %b want 0 0 1 0",
                 tag, prog_clk_en, busy, error, bs_ready);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    logic r;
    run_load(0, 12, -1, r);
    checks++;
    if (r !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_reached: reset applied %b want 1", r);
    end
    step;
    run_load(0, -1, -1, r);
    check_good_load("restart", 28, 28);
  endtask

  task automatic test_start_while_busy;
    logic r;
    run_load(0, -1, 10, r);
    check_good_load("busy_start", 28, 28);
  endtask

  initial begin
    pReset = 1'b0; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    test_reset();
    test_nominal();
    test_starvation();
    broken = 1'b1;
    test_tail_fault("broken");
    broken = 1'b0;
    stuck = 1'b1;
    test_tail_fault("stuck");
    stuck = 1'b0;
    test_reset_mid_load();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
